wdt_kicker: RTL
===============

Name: wdt_kicker

Overview:
- Controller-side counterpart to the reset supervisor (comp_reset). Drives the supervisor's watchdog input (s_wdi) and soft-reset request line (soft_rst_n).
- Lives in the FPGA/CPU domain, which comes out of reset on the supervisor's rst_n.
- Feeds the watchdog only while firmware heartbeats arrive. Releases wdi so the supervisor times out when firmware stalls.
- Issues a timed soft-reset pulse on request.

Parameters:
- CLK_DIV, 1000: clk cycles per 1 ms tick (1 MHz clk).
- START_MS, 100: delay from kick_en to first wdi drive.
- KICK_MS, 500: wdi half-period, i.e. interval between edges. Must be less than supervisor td (1600 ms).
- HB_MS, 1000: heartbeat timeout in ms.
- SRST_MS, 400: soft_rst_n low time. Must be greater than supervisor tp (280 ms max).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset (the supervisor's rst_n)
- kick_en  in  1  level; firmware enables watchdog feeding
- hb  in  1  one-cycle firmware heartbeat strobe
- soft_req  in  1  one-cycle soft-reset request strobe
- wdi_o  out  1  wdi data; pad is tri-stated when wdi_oe=0
- wdi_oe  out  1  wdi output enable
- srst_oe  out  1  open-drain enable; pad pulls soft_rst_n low when 1, hi-Z otherwise
- state_o  out  3  current FSM state
- starved  out  1  sticky: heartbeat timeout occurred

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low on rst_n; all flops clear immediately.
- Reset values: wdi_o=0, wdi_oe=0, srst_oe=0, starved=0, state=IDLE, all counters 0.
- Tick: free-running prescaler 0..CLK_DIV-1 starting at reset release. tick=1 for one cycle at terminal count.
- Timers: an N ms timer loads N on entry/reload and decrements on tick. It expires in the cycle its value reaches 0, so duration lies in ((N-1)*CLK_DIV, N*CLK_DIV] cycles.
- Outputs are registered; one cycle latency from state/timer event to pin.
- States:
  - IDLE: wdi_oe=0. kick_en=1 -> START, load START_MS.
  - START: wdi_oe=0. Timer expiry -> RUN with wdi_oe=1, wdi_o=0, kick timer=KICK_MS, hb timer=HB_MS. kick_en=0 -> IDLE.
  - RUN: wdi_oe=1; wdi_o toggles on each kick expiry, then kick timer reloads. hb=1 reloads hb timer. hb expiry -> STARVE and sets starved. kick_en=0 -> IDLE with wdi_oe=0, unless the lock feature applies.
  - STARVE: wdi_oe=0, wdi_o=0. Exits only via soft_req or rst_n. hb is ignored and does not recover.
  - SRST: entered from any state on soft_req. wdi_oe=0, srst_oe=1, load SRST_MS. Expiry -> HOLD.
  - HOLD: srst_oe=0, wdi_oe=0. Terminal; only rst_n exits. In-system the supervisor resets this block, so HOLD only persists if the supervisor fails.
- Priority in one cycle, highest first: soft_req > hb expiry > kick expiry > kick_en=0.
- hb in the same cycle as hb expiry: reload wins, no STARVE.
- soft_req while in SRST or HOLD: ignored; pulse is not extended.
- rst_n asserted mid-pulse: srst_oe drops asynchronously.
- Timer widths: ceil(log2(max ms param + 1)) bits. Prescaler width ceil(log2(CLK_DIV)). No wrap; a timer holds at 0 once expired.

Optional Feature:
- Macro WDT_KICK_LOCK_EN.
- Defined: a lock flop sets on the first entry to RUN. Once locked, kick_en=0 is ignored in START and RUN, so firmware cannot disable feeding. The lock clears only on rst_n.
- Undefined: kick_en=0 returns to IDLE as described above.

Decomposition:
- Shared package/include wdt_kick_pkg holds:
  - state encodings: IDLE=0, START=1, RUN=2, STARVE=3, SRST=4, HOLD=5
  - the timer-width function
  - default timing constants shared with the comp_reset bench
- One sub-module, ms_tick_gen: the prescaler with parameter CLK_DIV; outputs tick.
- Pad tri-state and open-drain drivers are instantiated at top level, not in this block.

Test Plan (CLK_DIV=4, START_MS=2, KICK_MS=5, HB_MS=12, SRST_MS=3):
- Release rst_n, kick_en=1 at cycle 10 -> wdi_oe rises 5-8 cycles later with wdi_o=0. wdi_o toggles every 20 cycles; hb every 30 cycles keeps state=RUN for 500 cycles.
- Stop hb -> STARVE 45-48 cycles after the last hb; wdi_oe=0, starved=1. A later hb leaves both unchanged.
- soft_req in RUN -> next cycle srst_oe=1, wdi_oe=0; srst_oe high 9-12 cycles; state=HOLD. Second soft_req during the pulse does not extend it.
- hb in the same cycle as hb expiry -> stays RUN. soft_req together with hb expiry -> SRST, starved stays 0.
- Assert rst_n mid-SRST -> srst_oe, wdi_oe, starved all 0 asynchronously; state=IDLE.
- kick_en=0 in RUN: without WDT_KICK_LOCK_EN -> IDLE, wdi_oe=0. With WDT_KICK_LOCK_EN -> stays RUN, toggling continues.

Source files
------------

// File: rtl/wdt_kick_pkg.sv
// wdt_kick_pkg: state encodings, timer sizing helper and default timing constants
// shared between wdt_kicker and the comp_reset bench.
package wdt_kick_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StRun    = 3'd2,
      StStarve = 3'd3,
      StSrst   = 3'd4,
      StHold   = 3'd5
   } state_t;

   // Default timing for a 1 MHz clock
   localparam int unsigned DefClkDiv  = 1000;
   localparam int unsigned DefStartMs = 100;
   localparam int unsigned DefKickMs  = 500;
   localparam int unsigned DefHbMs    = 1000;
   localparam int unsigned DefSrstMs  = 400;

   // Supervisor limits: kick interval must stay below td, soft reset must exceed tp
   localparam int unsigned SupTdMs    = 1600;
   localparam int unsigned SupTpMaxMs = 280;

   // Bits needed to hold a millisecond count of 0..max_ms
   function automatic int unsigned tmr_width(input int unsigned max_ms);
      return (max_ms < 1) ? 1 : $clog2(max_ms + 1);
   endfunction

endpackage

// File: rtl/wdt_kicker_ms_tick_gen.sv
// ms_tick_gen: free-running prescaler, one-cycle tick every CLK_DIV clocks.
module ms_tick_gen #(
   parameter int unsigned CLK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] Last = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..CLK_DIV-1 and wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == Last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == Last);

endmodule

// File: rtl/wdt_kicker.sv
// wdt_kicker: feeds the supervisor watchdog while firmware heartbeats arrive and
// issues a timed soft-reset pulse on request.
// Optional macro WDT_KICK_LOCK_EN: once RUN is reached, kick_en=0 is ignored until rst_n.
module wdt_kicker
   import wdt_kick_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DefClkDiv,
   parameter int unsigned START_MS = DefStartMs,
   parameter int unsigned KICK_MS  = DefKickMs,
   parameter int unsigned HB_MS    = DefHbMs,
   parameter int unsigned SRST_MS  = DefSrstMs
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       kick_en,
   input  logic       hb,
   input  logic       soft_req,
   output logic       wdi_o,
   output logic       wdi_oe,
   output logic       srst_oe,
   output logic [2:0] state_o,
   output logic       starved
);

   localparam int unsigned Max1  = (START_MS > KICK_MS) ? START_MS : KICK_MS;
   localparam int unsigned Max2  = (HB_MS > SRST_MS) ? HB_MS : SRST_MS;
   localparam int unsigned MaxMs = (Max1 > Max2) ? Max1 : Max2;
   localparam int unsigned TW    = tmr_width(MaxMs);

   localparam logic [TW-1:0] StartLoad = TW'(START_MS);
   localparam logic [TW-1:0] KickLoad  = TW'(KICK_MS);
   localparam logic [TW-1:0] HbLoad    = TW'(HB_MS);
   localparam logic [TW-1:0] SrstLoad  = TW'(SRST_MS);
   localparam logic [TW-1:0] One       = TW'(1);

   state_t        state;
   logic [TW-1:0] ph_tmr;    // START delay and SRST pulse share this timer
   logic [TW-1:0] kick_tmr;
   logic [TW-1:0] hb_tmr;
   logic          tick;
   logic          ph_exp, kick_exp, hb_exp, kick_off, srst_ok;

   ms_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // A timer expires in the cycle it steps from 1 to 0
   assign ph_exp   = tick && (ph_tmr == One);
   assign kick_exp = tick && (kick_tmr == One);
   // A heartbeat in the expiry cycle reloads instead of starving
   assign hb_exp   = tick && (hb_tmr == One) && !hb;
   assign srst_ok  = (state != StSrst) && (state != StHold);

`ifdef WDT_KICK_LOCK_EN
   logic locked;
   assign kick_off = !kick_en && !locked;
`else
   assign kick_off = !kick_en;
`endif

   assign state_o = state;

   // FSM, timers and registered pin outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         ph_tmr   <= '0;
         kick_tmr <= '0;
         hb_tmr   <= '0;
         wdi_o    <= 1'b0;
         wdi_oe   <= 1'b0;
         srst_oe  <= 1'b0;
         starved  <= 1'b0;
`ifdef WDT_KICK_LOCK_EN
         locked   <= 1'b0;
`endif
      end else begin
         // Background countdown; loads below override. Timers hold at 0.
         if (tick && ph_tmr != '0) ph_tmr <= ph_tmr - One;
         if (tick && kick_tmr != '0) kick_tmr <= kick_tmr - One;
         if (hb) begin
            hb_tmr <= HbLoad;
         end else if (tick && hb_tmr != '0) begin
            hb_tmr <= hb_tmr - One;
         end

         if (soft_req && srst_ok) begin
            state   <= StSrst;
            srst_oe <= 1'b1;
            wdi_oe  <= 1'b0;
            wdi_o   <= 1'b0;
            ph_tmr  <= SrstLoad;
         end else begin
            case (state)
               StIdle: begin
                  if (kick_en) begin
                     state  <= StStart;
                     ph_tmr <= StartLoad;
                  end
               end
               StStart: begin
                  if (kick_off) begin
                     state <= StIdle;
                  end else if (ph_exp) begin
                     state    <= StRun;
                     wdi_oe   <= 1'b1;
                     wdi_o    <= 1'b0;
                     kick_tmr <= KickLoad;
                     hb_tmr   <= HbLoad;
`ifdef WDT_KICK_LOCK_EN
                     locked   <= 1'b1;
`endif
                  end
               end
               StRun: begin
                  if (hb_exp) begin
                     state   <= StStarve;
                     starved <= 1'b1;
                     wdi_oe  <= 1'b0;
                     wdi_o   <= 1'b0;
                  end else if (kick_exp) begin
                     wdi_o    <= ~wdi_o;
                     kick_tmr <= KickLoad;
                  end else if (kick_off) begin
                     state  <= StIdle;
                     wdi_oe <= 1'b0;
                     wdi_o  <= 1'b0;
                  end
               end
               StSrst: begin
                  if (ph_exp) begin
                     state   <= StHold;
                     srst_oe <= 1'b0;
                  end
               end
               StStarve, StHold: begin
                  // Terminal until soft_req (STARVE) or rst_n
               end
               default: begin
                  state <= StIdle;
               end
            endcase
         end
      end
   end

endmodule
